gcd_arbiter: RTL and testbench
==============================

// Module: gcd_arbiter
// PURPOSE
//  Shares one gcd unit among N requesters; requests are granted round-robin.
//  Sits between the requester ports and a single gcd instance, which it
//  drives through the gcd operands/result val/rdy interface.
//  Exactly one job is in flight at a time. Each result returns only to the
//  requester that issued it, tagged with that requester's index.
// PARAMETERS
//  W   16  operand/result width; must equal the gcd instance width
//  N   4   number of requesters (2..8)
//  IW  $clog2(N)  requester index width (derived, not overridable)
// PORTS
//  clk               in   1     single clock, rising edge
//  reset             in   1     asynchronous, active-high
//  req_val           in   N     per-requester operand valid
//  req_rdy           out  N     per-requester operand ready (one-hot or zero)
//  req_bits_A        in   N*W   operand A, requester i at [i*W +: W]
//  req_bits_B        in   N*W   operand B, requester i at [i*W +: W]
//  resp_val          out  N     per-requester result valid (one-hot or zero)
//  resp_rdy          in   N     per-requester result ready
//  resp_bits_data    out  W     result data, shared by all requesters
//  resp_id           out  IW    index of requester owning resp_bits_data
//  gcd_operands_A    out  W     to gcd operands_bits_A
//  gcd_operands_B    out  W     to gcd operands_bits_B
//  gcd_operands_val  out  1     to gcd operands_val
//  gcd_operands_rdy  in   1     from gcd operands_rdy
//  gcd_result_data   in   W     from gcd result_bits_data
//  gcd_result_val    in   1     from gcd result_val
//  gcd_result_rdy    out  1     to gcd result_rdy
//  busy              out  1     high whenever state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, owner=0. All registered A/B/data = 0.
//   All outputs are 0 during reset.
//  A handshake on any port occurs on the rising clk edge where val&rdy=1.
//  IDLE:
//   - Winner = first i with req_val[i]=1, searching from rr_ptr upward and
//     wrapping mod N.
//   - req_rdy[winner]=1 combinationally; all other req_rdy bits = 0.
//   - On that edge, latch A, B and owner=winner, then go to ISSUE.
//   - If no req_val bit is set, stay in IDLE.
//  ISSUE:
//   - gcd_operands_val=1 and gcd_operands_A/B = latched values.
//   - Go to WAIT on the edge where gcd_operands_rdy=1.
//  WAIT:
//   - gcd_result_rdy=1.
//   - On gcd_result_val=1, latch gcd_result_data and go to RESP.
//  RESP:
//   - resp_val[owner]=1, resp_bits_data = latched result, resp_id=owner.
//   - On resp_rdy[owner]=1: rr_ptr=(owner+1) mod N, then go to IDLE.
//   - Holds indefinitely under backpressure. Other requesters are not served.
//  Outside its state: req_rdy, resp_val, gcd_operands_val and gcd_result_rdy = 0.
//  Minimum latency, request accept to resp_val: 2 + gcd compute cycles.
//  Request stalls are required, and an IDLE accept may occur on the cycle after RESP completes.
//  Fairness: with all N requesters continuously valid, grants follow
//   0,1,..,N-1,0. The most recently served requester is always last priority.
//  Boundary conditions:
//   - req_val dropped before its grant: no effect, nothing is latched.
//   - resp_rdy from a non-owner is ignored.
//   - Result 0 (A=B=0) is a valid result and is delivered normally.
//   - gcd_result_val outside WAIT is ignored.
//   - Reset mid-job aborts immediately and the result is discarded.
//     The gcd instance shares clk/reset, so both sides clear together.
//  Widths: all data paths are W bits with no arithmetic. rr_ptr wraps mod N,
//   including when N is not a power of two.
// STRUCTURE
//  Package gcd_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP) as 2-bit localparams.
//  Sub-module rr_arbiter #(N) is combinational:
//   - inputs: req vector, rr_ptr; output: one-hot grant + index.
//  The FSM, operand/result registers and rr_ptr live in gcd_arbiter.
// TESTING (bench instantiates gcd #(16) + gcd_arbiter #(16,4))
//  1 Only req0 valid with A=27, B=15:
//    -> resp_val[0] with data=3 and resp_id=0; req_rdy stays 0 for other ports.
//  2 All 4 requesters valid, pairs (21,49),(25,30),(19,27),(40,40):
//    -> responses in order id 0,1,2,3 with data 7,5,1,40.
//  3 After id 2 is served, only req1 and req3 valid:
//    -> req3 is granted first, then req1.
//  4 resp_rdy[1]=0 for 20 cycles on a job for id1 (250,190):
//    -> resp_val[1] and data=10 held stable; req_rdy stays 0 throughout.
//  5 reset pulsed while in WAIT on a job (5,250):
//    -> outputs are 0 asynchronously, and no resp_val is seen afterwards.
//    -> The next request (0,0) returns 0.
//  6 Random val/rdy on all ports, 200 jobs checked against a reference GCD:
//    -> every result is correct and routed to its issuer.
//    -> No requester waits more than N-1 other grants.

Source files
------------

// File: rtl/gcd_arb_pkg.sv
// Shared definitions for the gcd round-robin arbiter.
package gcd_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t RESP  = 2'd3;

endpackage

// File: rtl/gcd_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping mod N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            // one spare bit so the sum cannot overflow before the wrap
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_any && req[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares a single gcd unit among N requesters, one job in flight, round-robin grants.
//  state | meaning
//  IDLE  | pick a winner, latch its operands
//  ISSUE | present operands to the gcd unit
//  WAIT  | accept the gcd result
//  RESP  | hold the result for the owner until it is taken
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter  int W  = 16,
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_val,
    output logic [N-1:0]    req_rdy,
    input  logic [N*W-1:0]  req_bits_A,
    input  logic [N*W-1:0]  req_bits_B,
    output logic [N-1:0]    resp_val,
    input  logic [N-1:0]    resp_rdy,
    output logic [W-1:0]    resp_bits_data,
    output logic [IW-1:0]   resp_id,
    output logic [W-1:0]    gcd_operands_A,
    output logic [W-1:0]    gcd_operands_B,
    output logic            gcd_operands_val,
    input  logic            gcd_operands_rdy,
    input  logic [W-1:0]    gcd_result_data,
    input  logic            gcd_result_val,
    output logic            gcd_result_rdy,
    output logic            busy
);

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [W-1:0]  a_q, b_q, data_q;

    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_any;

    rr_arbiter #(.N(N)) u_rr (
        .req       (req_val),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any)        state_nxt = ISSUE;
            ISSUE:   if (gcd_operands_rdy) state_nxt = WAIT;
            WAIT:    if (gcd_result_val)   state_nxt = RESP;
            RESP:    if (resp_rdy[owner])  state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            owner  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner <= grant_idx;
                        a_q   <= req_bits_A[grant_idx*W +: W];
                        b_q   <= req_bits_B[grant_idx*W +: W];
                    end
                end
                WAIT: begin
                    if (gcd_result_val) begin
                        data_q <= gcd_result_data;
                    end
                end
                RESP: begin
                    // explicit wrap keeps the pointer legal for non-power-of-two N
                    if (resp_rdy[owner]) begin
                        rr_ptr <= (owner == IW'(N-1)) ? '0 : owner + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_rdy          = '0;
        resp_val         = '0;
        gcd_operands_val = 1'b0;
        gcd_result_rdy   = 1'b0;
        busy             = (state != IDLE);
        resp_bits_data   = data_q;
        resp_id          = owner;
        gcd_operands_A   = a_q;
        gcd_operands_B   = b_q;
        case (state)
            IDLE:    if (!reset) req_rdy = grant;
            ISSUE:   gcd_operands_val = 1'b1;
            WAIT:    gcd_result_rdy   = 1'b1;
            RESP:    resp_val[owner]  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural gcd responder, protocol-level model and directed/random jobs.
module tb_gcd_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_val;
    logic [N-1:0]    req_rdy;
    logic [N*W-1:0]  req_bits_A;
    logic [N*W-1:0]  req_bits_B;
    logic [N-1:0]    resp_val;
    logic [N-1:0]    resp_rdy;
    logic [W-1:0]    resp_bits_data;
    logic [IW-1:0]   resp_id;
    logic [W-1:0]    gcd_operands_A;
    logic [W-1:0]    gcd_operands_B;
    logic            gcd_operands_val;
    logic            gcd_operands_rdy;
    logic [W-1:0]    gcd_result_data;
    logic            gcd_result_val;
    logic            gcd_result_rdy;
    logic            busy;

    always #5 clk = ~clk;

    gcd_arbiter #(.W(W), .N(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_val          (req_val),
        .req_rdy          (req_rdy),
        .req_bits_A       (req_bits_A),
        .req_bits_B       (req_bits_B),
        .resp_val         (resp_val),
        .resp_rdy         (resp_rdy),
        .resp_bits_data   (resp_bits_data),
        .resp_id          (resp_id),
        .gcd_operands_A   (gcd_operands_A),
        .gcd_operands_B   (gcd_operands_B),
        .gcd_operands_val (gcd_operands_val),
        .gcd_operands_rdy (gcd_operands_rdy),
        .gcd_result_data  (gcd_result_data),
        .gcd_result_val   (gcd_result_val),
        .gcd_result_rdy   (gcd_result_rdy),
        .busy             (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_mode = 1'b0;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: one job in flight, phases follow the handshakes seen on the ports.
    int           phase_m;
    int           owner_m;
    int           ptr_m;
    logic [W-1:0] a_m, b_m;
    int           waited [N];
    logic [N-1:0] hs_req;
    int           grant_log [$];
    int           resp_id_log [$];
    logic [W-1:0] resp_data_log [$];

    initial begin
        bit           g_any, g_hs, o_hs, r_hs, p_hs;
        int           idx;
        logic [N-1:0] exp_rdy, exp_rv;
        logic [W-1:0] rd;
        phase_m = 0; owner_m = 0; ptr_m = 0; a_m = '0; b_m = '0; hs_req = '0;
        for (int i = 0; i < N; i++) waited[i] = 0;
        forever begin
            @(negedge clk);
            g_hs = 0; o_hs = 0; r_hs = 0; p_hs = 0; idx = 0; rd = resp_bits_data;
            if (reset) begin
                chk("rst_req_rdy",  64'(req_rdy), 64'(0));
                chk("rst_resp_val", 64'(resp_val), 64'(0));
                chk("rst_busy",     64'(busy), 64'(0));
                chk("rst_op_val",   64'(gcd_operands_val), 64'(0));
                chk("rst_res_rdy",  64'(gcd_result_rdy), 64'(0));
                chk("rst_data",     64'(resp_bits_data), 64'(0));
                chk("rst_id",       64'(resp_id), 64'(0));
                phase_m = 0; ptr_m = 0; owner_m = 0;
                for (int i = 0; i < N; i++) waited[i] = 0;
            end else begin
                g_any = 0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (ptr_m + k) % N;
                    if (!g_any && req_val[c]) begin
                        g_any = 1;
                        idx = c;
                    end
                end
                exp_rdy = (phase_m == 0 && g_any) ? (N'(1) << idx) : '0;
                exp_rv  = (phase_m == 3) ? (N'(1) << owner_m) : '0;
                chk("req_rdy",  64'(req_rdy), 64'(exp_rdy));
                chk("busy",     64'(busy), 64'(phase_m != 0));
                chk("op_val",   64'(gcd_operands_val), 64'(phase_m == 1));
                chk("res_rdy",  64'(gcd_result_rdy), 64'(phase_m == 2));
                chk("resp_val", 64'(resp_val), 64'(exp_rv));
                if (phase_m == 1) begin
                    chk("op_A", 64'(gcd_operands_A), 64'(a_m));
                    chk("op_B", 64'(gcd_operands_B), 64'(b_m));
                end
                if (phase_m == 3) begin
                    chk("resp_data", 64'(resp_bits_data), 64'(ref_gcd(a_m, b_m)));
                    chk("resp_id",   64'(resp_id), 64'(owner_m));
                end
                for (int i = 0; i < N; i++) if (!req_val[i]) waited[i] = 0;
                g_hs = (phase_m == 0) && g_any;
                o_hs = (phase_m == 1) && gcd_operands_rdy;
                r_hs = (phase_m == 2) && gcd_result_val;
                p_hs = (phase_m == 3) && resp_rdy[owner_m];
                if (g_hs) chk("fairness", 64'(waited[idx] <= N-1), 64'(1));
            end
            @(posedge clk);
            hs_req = '0;
            if (g_hs) begin
                for (int i = 0; i < N; i++) if (i != idx && req_val[i]) waited[i]++;
                waited[idx] = 0;
                owner_m = idx;
                a_m = req_bits_A[idx*W +: W];
                b_m = req_bits_B[idx*W +: W];
                grant_log.push_back(idx);
                hs_req[idx] = 1'b1;
                phase_m = 1;
            end
            if (o_hs) phase_m = 2;
            if (r_hs) phase_m = 3;
            if (p_hs) begin
                resp_id_log.push_back(owner_m);
                resp_data_log.push_back(rd);
                ptr_m = (owner_m + 1) % N;
                phase_m = 0;
            end
        end
    end

    // Behavioural gcd unit sharing clk/reset with the arbiter.
    initial begin
        bit           g_busy, op_hs, res_hs;
        int           g_cnt;
        logic [W-1:0] g_res, oa, ob;
        gcd_operands_rdy = 1'b0; gcd_result_val = 1'b0; gcd_result_data = '0;
        g_busy = 0; g_cnt = 0; g_res = '0; oa = '0; ob = '0;
        forever begin
            @(negedge clk);
            op_hs = 0; res_hs = 0;
            if (reset) begin
                g_busy = 0;
                gcd_operands_rdy = 1'b0;
                gcd_result_val = 1'b0;
            end else begin
                op_hs  = gcd_operands_val && gcd_operands_rdy;
                res_hs = gcd_result_val && gcd_result_rdy;
                oa = gcd_operands_A;
                ob = gcd_operands_B;
            end
            @(posedge clk);
            #1;
            if (res_hs) begin
                g_busy = 0;
                gcd_result_val = 1'b0;
            end
            if (op_hs) begin
                g_busy = 1;
                g_cnt  = rand_mode ? int'($urandom_range(0, 6)) : 4;
                g_res  = ref_gcd(oa, ob);
                gcd_result_val = 1'b0;
            end
            if (g_busy) begin
                if (!gcd_result_val) begin
                    if (g_cnt == 0) begin
                        gcd_result_val  = 1'b1;
                        gcd_result_data = g_res;
                    end else begin
                        g_cnt--;
                    end
                end
            end else if (rand_mode) begin
                // stray results while nobody is waiting must be ignored
                gcd_result_val  = ($urandom_range(0, 7) == 0);
                gcd_result_data = W'($urandom);
            end else begin
                gcd_result_val = 1'b0;
            end
            gcd_operands_rdy = !g_busy && (!rand_mode || $urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_val = req_val & ~hs_req;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_bits_A[i*W +: W] = a;
        req_bits_B[i*W +: W] = b;
        req_val[i] = 1'b1;
    endtask

    task automatic wait_resps(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (resp_id_log.size() < target && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_done"}, 64'(resp_id_log.size() >= target), 64'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_val = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 12));
        return W'($urandom);
    endfunction

    initial begin
        int           base, gb, k;
        logic [W-1:0] exp2 [4];
        exp2 = '{16'd7, 16'd5, 16'd1, 16'd40};
        reset = 1'b1; req_val = '0; req_bits_A = '0; req_bits_B = '0; resp_rdy = '0;
        repeat (2) @(posedge clk);
        #1;
        req_val = '1;
        #1;
        chk("reset_gates_req_rdy", 64'(req_rdy), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        req_val = '0;
        tick();
        reset = 1'b0;
        tick();

        // single requester
        resp_rdy = '1;
        base = resp_id_log.size();
        set_req(0, 16'd27, 16'd15);
        wait_resps(base + 1, 100, "t1");
        if (resp_id_log.size() > base) begin
            chk("t1_id", 64'(resp_id_log[base]), 64'(0));
            chk("t1_data", 64'(resp_data_log[base]), 64'(3));
        end

        // all requesters, from a fresh pointer
        do_reset();
        base = resp_id_log.size();
        set_req(0, 16'd21, 16'd49);
        set_req(1, 16'd25, 16'd30);
        set_req(2, 16'd19, 16'd27);
        set_req(3, 16'd40, 16'd40);
        wait_resps(base + 4, 200, "t2");
        if (resp_id_log.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_id", 64'(resp_id_log[base+i]), 64'(i));
                chk("t2_data", 64'(resp_data_log[base+i]), 64'(exp2[i]));
            end
        end

        // after id 2 is served, id 3 outranks id 1
        base = resp_id_log.size();
        set_req(2, 16'd12, 16'd18);
        wait_resps(base + 1, 100, "t3a");
        gb = grant_log.size();
        set_req(1, 16'd9, 16'd6);
        set_req(3, 16'd14, 16'd21);
        wait_resps(base + 3, 200, "t3b");
        if (grant_log.size() >= gb + 2 && resp_data_log.size() >= base + 3) begin
            chk("t3_first", 64'(grant_log[gb]), 64'(3));
            chk("t3_second", 64'(grant_log[gb+1]), 64'(1));
            chk("t3_data3", 64'(resp_data_log[base+1]), 64'(7));
            chk("t3_data1", 64'(resp_data_log[base+2]), 64'(3));
        end

        // response backpressure on id 1
        base = resp_id_log.size();
        resp_rdy = 4'b1101;
        set_req(1, 16'd250, 16'd190);
        k = 0;
        while (!hs_req[1] && k < 20) begin tick(); k++; end
        set_req(0, 16'd3, 16'd9);
        set_req(2, 16'd8, 16'd12);
        k = 0;
        while (!resp_val[1] && k < 50) begin tick(); k++; end
        chk("t4_reached_resp", 64'(resp_val), 64'(4'b0010));
        repeat (20) begin
            tick();
            chk("t4_hold_val", 64'(resp_val), 64'(4'b0010));
            chk("t4_hold_data", 64'(resp_bits_data), 64'(10));
            chk("t4_no_grant", 64'(req_rdy), 64'(0));
        end
        resp_rdy = '1;
        wait_resps(base + 3, 200, "t4");

        // reset while waiting on the gcd unit
        base = resp_id_log.size();
        set_req(0, 16'd5, 16'd250);
        k = 0;
        while (!gcd_result_rdy && k < 30) begin tick(); k++; end
        chk("t5_in_wait", 64'(gcd_result_rdy), 64'(1));
        reset = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_res_rdy", 64'(gcd_result_rdy), 64'(0));
        chk("t5_resp_val", 64'(resp_val), 64'(0));
        chk("t5_op_A", 64'(gcd_operands_A), 64'(0));
        chk("t5_req_rdy", 64'(req_rdy), 64'(0));
        req_val = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) begin
            tick();
            chk("t5_no_resp", 64'(resp_val), 64'(0));
        end
        chk("t5_discarded", 64'(resp_id_log.size()), 64'(base));
        set_req(0, 16'd0, 16'd0);
        wait_resps(base + 1, 100, "t5");
        if (resp_id_log.size() > base) begin
            chk("t5_zero_data", 64'(resp_data_log[base]), 64'(0));
            chk("t5_zero_id", 64'(resp_id_log[base]), 64'(0));
        end

        // random traffic
        rand_mode = 1'b1;
        base = resp_id_log.size();
        k = 0;
        while (resp_id_log.size() < base + 200 && k < 20000) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req_val[i]) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, rnd_op(), rnd_op());
                end else if ($urandom_range(0, 15) == 0) begin
                    req_val[i] = 1'b0;
                end
            end
            resp_rdy = N'($urandom);
            k++;
        end
        chk("t6_done", 64'(resp_id_log.size() >= base + 200), 64'(1));
        rand_mode = 1'b0;
        resp_rdy = '1;
        req_val = '0;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
